// File: rtl/sr04_echo_responder.sv
// HC-SR04 sensor-side responder: validates trig, waits the burst delay, then drives echo for dist_cm*US_PER_CM ticks.
// Trig-to-detect latency is 3 clk and there is no backpressure; SR04_ECHO_JITTER_EN adds 0..7 ticks of LFSR jitter to echo.
module sr04_echo_responder #(
  parameter int unsigned MIN_TRIG_US   = 10,
  parameter int unsigned ECHO_DELAY_US = 200,
  parameter int unsigned US_PER_CM     = 58,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic       meas_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    DELAY   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_e;

  localparam logic [15:0] MIN_W     = 16'(MIN_TRIG_US);
  localparam logic [15:0] DLY_LAST  = 16'(ECHO_DELAY_US - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_US - 1);
  localparam logic [15:0] TMO_W     = 16'(TIMEOUT_US);
  localparam logic [15:0] MAX_W     = 16'(MAX_CM);
  localparam logic [15:0] PER_CM_W  = 16'(US_PER_CM);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] w_reg_q, w_reg_d;
  logic        trig_s1_q, trig_s1_d;
  logic        trig_s_q, trig_s_d;
  logic        trig_p_q, trig_p_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        trig_err_q, trig_err_d;
  logic        meas_done_q, meas_done_d;

  logic        trig_rise, trig_fall, latch, timeout_path;
  logic [15:0] w_exact, w_new;

  assign trig_rise = trig_s_q & ~trig_p_q;
  assign trig_fall = ~trig_s_q & trig_p_q;
  assign latch     = (state_q == TRIG_HI) && trig_fall && (cnt_q >= MIN_W);

  always_comb begin
    timeout_path = 1'b0;
    if (dist_cm == 9'd0) begin
      w_exact = 16'd1;
    end else if (16'(dist_cm) > MAX_W) begin
      w_exact      = TMO_W;
      timeout_path = 1'b1;
    end else begin
      w_exact = 16'(dist_cm) * PER_CM_W;
    end
  end

`ifdef SR04_ECHO_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [16:0] w_sum;

  always_comb begin
    w_sum = {1'b0, w_exact} + {14'd0, lfsr_q[2:0]};
    if (timeout_path) begin
      w_new = w_exact;
    end else begin
      w_new = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, one step per measurement
    lfsr_d = lfsr_q;
    if (latch) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  always_comb begin
    w_new = w_exact;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      w_reg_q     <= 16'd0;
      trig_s1_q   <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_p_q    <= 1'b0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      meas_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_reg_q     <= w_reg_d;
      trig_s1_q   <= trig_s1_d;
      trig_s_q    <= trig_s_d;
      trig_p_q    <= trig_p_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      trig_err_q  <= trig_err_d;
      meas_done_q <= meas_done_d;
    end
  end

  always_comb begin
    trig_s1_d = trig;
    trig_s_d  = trig_s1_q;
    trig_p_d  = trig_s_q;
    state_d   = state_q;
    w_reg_d   = latch ? w_new : w_reg_q;
    case (state_q)
      IDLE:    if (trig_rise) state_d = TRIG_HI;
      TRIG_HI: if (trig_fall) state_d = (cnt_q >= MIN_W) ? DELAY : IDLE;
      DELAY:   if (i_tick && cnt_q == DLY_LAST) state_d = ECHO;
      ECHO:    if (i_tick && cnt_q == w_reg_q - 16'd1) state_d = HOLDOFF;
      HOLDOFF: if (i_tick && cnt_q == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // shared counter restarts on every state change; trigger width saturates
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (i_tick && !(state_q == TRIG_HI && cnt_q >= MIN_W)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    echo_d      = (state_d == ECHO);
    busy_d      = (state_d != IDLE);
    trig_err_d  = (state_q == TRIG_HI) && (state_d == IDLE);
    meas_done_d = (state_q == ECHO) && (state_d == HOLDOFF);
  end

  assign echo      = echo_q;
  assign busy      = busy_q;
  assign trig_err  = trig_err_q;
  assign meas_done = meas_done_q;

endmodule

// File: tb/tb_sr04_echo_responder.sv
// Bench for sr04_echo_responder: randomized tick spacing, directed and random triggers, widths checked against a rule model.
module tb_sr04_echo_responder;
  localparam int HOLD = 100;
  localparam int TMO  = 1900;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_tick = 1'b0;
  logic       trig = 1'b0;
  logic [8:0] dist_cm = 9'd0;
  logic       echo, busy, trig_err, meas_done;

  int total = 0;
  int bad   = 0;
  bit tick_en = 1'b0;

  int   tick_cnt = 0, echo_ticks = 0, rise_cnt = 0, md_cnt = 0, err_cnt = 0, md_bad = 0;
  logic prev_echo = 1'b0;
  int   fall_mark = 0;

  always #5 clk = ~clk;

  sr04_echo_responder #(
    .MIN_TRIG_US(10), .ECHO_DELAY_US(200), .US_PER_CM(58), .MAX_CM(400),
    .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .trig(trig), .dist_cm(dist_cm),
    .echo(echo), .busy(busy), .trig_err(trig_err), .meas_done(meas_done)
  );

  // ticks arrive on roughly two clocks out of three, with random gaps
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_tick = tick_en && ($urandom_range(0, 2) != 0);
    end
  end

  // observer: counts ticks, echo-high ticks and output pulses
  initial begin
    forever begin
      @(negedge clk);
      if (i_tick) tick_cnt++;
      if (echo && i_tick) echo_ticks++;
      if (echo && !prev_echo) rise_cnt++;
      if (meas_done) begin
        md_cnt++;
        if (!(prev_echo && !echo)) md_bad++;
      end
      if (trig_err) err_cnt++;
      prev_echo = echo;
    end
  end

  function automatic int ref_lo(int d);
    if (d == 0) return 1;
    if (d > 400) return TMO;
    return d * 58;
  endfunction

  function automatic int ref_hi(int d);
`ifdef SR04_ECHO_JITTER_EN
    if (d > 400) return TMO;
    return ref_lo(d) + 7;
`else
    return ref_lo(d);
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic wait_ticks(input int n);
    int m;
    m = tick_cnt;
    while (tick_cnt - m < n) step();
  endtask

  task automatic pulse_trig(input int tw);
    trig = 1'b1;
    wait_ticks(tw);
    trig = 1'b0;
  endtask

  task automatic fire(input int d, input int tw);
    dist_cm    = 9'(d);
    echo_ticks = 0;
    pulse_trig(tw);
    fall_mark = tick_cnt;
  endtask

  task automatic wait_rise(input string tag);
    int b;
    b = 0;
    while (!echo && b < 3000) begin
      step();
      b++;
    end
    if (echo) chk_rng({tag, "_delay"}, tick_cnt - fall_mark, 199, 205);
    else timeout_fail({tag, "_rise"});
  endtask

  task automatic wait_fall(input string tag, input int d, output int w, output int mark);
    int b;
    b = 0;
    while (echo && b < (ref_hi(d) + 20) * 4) begin
      step();
      b++;
    end
    mark = tick_cnt;
    w    = echo_ticks;
    if (echo) timeout_fail({tag, "_fall"});
    else chk_rng({tag, "_width"}, w, ref_lo(d) - 1, ref_hi(d) + 1);
  endtask

  task automatic wait_idle(input string tag, input int mark);
    int b;
    b = 0;
    while (busy && b < 2000) begin
      step();
      b++;
    end
    if (busy) timeout_fail({tag, "_idle"});
    else chk_rng({tag, "_hold"}, tick_cnt - mark, HOLD - 1, HOLD + 2);
  endtask

  task automatic meas(input int d, input int tw, input string tag);
    int md0, w, mk;
    md0 = md_cnt;
    fire(d, tw);
    wait_rise(tag);
    wait_fall(tag, d, w, mk);
    chk({tag, "_md"}, md_cnt - md0, 1);
    wait_idle(tag, mk);
  endtask

  initial begin
    int md0, r0, e0, b, w, mk, d;
    int wmin, wmax;

    repeat (3) step();
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(trig_err), 0);
    chk("rst_md", int'(meas_done), 0);
    rst = 1'b1;
    tick_en = 1'b1;
    repeat (5) step();

    // nominal 100 cm, with a tick stall mid-echo
    md0 = md_cnt;
    fire(100, 12);
    chk("d100_busy_trig", int'(busy), 1);
    wait_rise("d100");
    tick_en = 1'b0;
    repeat (40) step();
    chk("stall_echo", int'(echo), 1);
    chk("stall_md", md_cnt - md0, 0);
    tick_en = 1'b1;
    wait_fall("d100", 100, w, mk);
    chk("d100_md", md_cnt - md0, 1);
    chk("d100_busy_hold", int'(busy), 1);
    wait_idle("d100", mk);

    // short trigger is rejected
    e0 = err_cnt;
    r0 = rise_cnt;
    dist_cm = 9'd50;
    pulse_trig(5);
    b = 0;
    while (!trig_err && b < 20) begin
      step();
      b++;
    end
    chk_rng("err_latency", b, 2, 6);
    wait_ticks(300);
    chk("err_count", err_cnt - e0, 1);
    chk("err_no_echo", rise_cnt - r0, 0);
    chk("err_busy", int'(busy), 0);

    meas(401, 15, "d401");
    meas(0, 12, "d0");

    // distance change after the latch has no effect
    fire(200, 12);
    wait_ticks(50);
    dist_cm = 9'd10;
    wait_rise("d200chg");
    wait_fall("d200chg", 200, w, mk);
    wait_idle("d200chg", mk);

    // triggers during ECHO and HOLDOFF are ignored
    r0 = rise_cnt;
    fire(100, 12);
    wait_rise("ign");
    wait_ticks(1000);
    pulse_trig(12);
    wait_fall("ign", 100, w, mk);
    pulse_trig(12);
    wait_idle("ign", mk);
    wait_ticks(300);
    chk("ign_single", rise_cnt - r0, 1);
    meas(int'($urandom_range(1, 20)), 14, "after_hold");

    // reset mid-echo
    md0 = md_cnt;
    fire(100, 12);
    wait_rise("rstmid");
    wait_ticks(500);
    rst = 1'b0;
    #1;
    chk("rstmid_echo", int'(echo), 0);
    chk("rstmid_busy", int'(busy), 0);
    step();
    chk("rstmid_md", md_cnt - md0, 0);
    rst = 1'b1;
    step();
    meas(33, 12, "post_rst");

    // random valid and short triggers
    for (int i = 0; i < 5; i++) begin
      d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(401, 511)) : int'($urandom_range(0, 15));
      meas(d, int'($urandom_range(13, 20)), "rnd");
      e0 = err_cnt;
      r0 = rise_cnt;
      dist_cm = 9'($urandom_range(0, 511));
      pulse_trig(int'($urandom_range(1, 6)));
      wait_ticks(260);
      chk("rnd_err", err_cnt - e0, 1);
      chk("rnd_err_noecho", rise_cnt - r0, 0);
    end

`ifdef SR04_ECHO_JITTER_EN
    wmin = 1 << 30;
    wmax = 0;
    for (int i = 0; i < 16; i++) begin
      fire(10, 12);
      wait_rise("jit");
      wait_fall("jit", 10, w, mk);
      wait_idle("jit", mk);
      if (w < wmin) wmin = w;
      if (w > wmax) wmax = w;
    end
    chk("jit_vary", int'(wmax > wmin), 1);
`endif

    chk("md_at_fall", md_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr04_echo_responder.md
Name: sr04_echo_responder

Overview:
- Sensor-side model of the HC-SR04 ultrasonic ranger: the responder end of the trig/echo interface driven by our sr04 controller.
- Watches trig, checks for a valid trigger pulse, waits a fixed burst delay, then drives echo high for dist_cm*US_PER_CM microseconds.
- Used in loopback builds and benches so the sr04 path can be exercised without a physical sensor.
- Time base is the shared 1 us tick from tick_gen_1us.

Parameters:
- MIN_TRIG_US, 10, minimum trig high width in ticks for a valid trigger.
- ECHO_DELAY_US, 200, ticks from trig fall to echo rise (emulated 8-cycle burst).
- US_PER_CM, 58, echo ticks per centimetre.
- MAX_CM, 400, largest in-range distance.
- TIMEOUT_US, 38000, echo width for out-of-range distance (dist_cm > MAX_CM).
- HOLDOFF_US, 60000, ticks after echo fall during which trig is ignored.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- i_tick  input  1  one-clk pulse every 1 us.
- trig  input  1  trigger from controller; treated as asynchronous, 2-flop synchronised.
- dist_cm  input  9  emulated target distance in cm; sampled at trig fall.
- echo  output  1  echo pulse, registered.
- busy  output  1  high in any state other than IDLE.
- trig_err  output  1  one-clk pulse when a trigger shorter than MIN_TRIG_US is rejected.
- meas_done  output  1  one-clk pulse on the cycle echo falls.

Behaviour:
- Reset (rst=0, async): state IDLE; echo=0, busy=0, trig_err=0, meas_done=0; counter=0; synchroniser flops=0; latched width=0.
- trig passes through a 2-flop synchroniser (trig_s). Edges are detected against a third flop, so trig-to-detect latency is 3 clk.
- One 16-bit tick counter cnt serves all states. It increments only on i_tick and clears on every state change.
- IDLE: on trig_s rising edge go to TRIG_HI with cnt=0.
- TRIG_HI:
  - Count ticks while trig_s=1. Saturate at MIN_TRIG_US.
  - On trig_s falling edge with cnt >= MIN_TRIG_US: latch the echo width into w_reg, then go to DELAY.
  - On trig_s falling edge with cnt < MIN_TRIG_US: pulse trig_err for 1 clk and return to IDLE. Echo never rises.
- Width rule (16-bit result):
  - dist_cm == 0 -> w_reg = 1.
  - 1 <= dist_cm <= MAX_CM -> w_reg = dist_cm*US_PER_CM.
  - dist_cm > MAX_CM -> w_reg = TIMEOUT_US.
  - Changing dist_cm after the latch has no effect on the current measurement.
- DELAY: on the i_tick where cnt reaches ECHO_DELAY_US-1, go to ECHO. echo=1 from the next clk.
- ECHO:
  - echo held 1.
  - On the i_tick where cnt reaches w_reg-1, go to HOLDOFF. echo=0 from the next clk, and meas_done pulses on that same cycle.
  - Echo high time is exactly w_reg ticks, +/-1 tick of phase.
- HOLDOFF: echo=0. trig edges are ignored. After HOLDOFF_US ticks go to IDLE.
- trig activity in DELAY, ECHO or HOLDOFF is ignored and is not queued. A trig already high when IDLE is entered is not a rising edge; it needs a new 0->1 transition.
- i_tick stuck low: the FSM stalls in its current state with outputs frozen. This is legal, and there is no watchdog.
- Reset asserted mid-ECHO: echo drops to 0 asynchronously and no meas_done is issued.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro SR04_ECHO_JITTER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per latched measurement.
  - Its low 3 bits (0..7) are added to w_reg at latch time, saturating at 16'hFFFF, to model sensor jitter.
  - The TIMEOUT_US path is not jittered.
- Not defined: the LFSR is absent and the width is exact per the width rule.

Test Plan:
- dist_cm=100, 12 us trig -> echo rises 200 us (+/-1) after trig fall; echo high 5800 ticks (+/-1); meas_done one pulse at fall; busy high throughout until holdoff ends.
- 5 us trig, dist_cm=50 -> trig_err one pulse about 3 clk after trig fall; echo stays 0; busy returns 0.
- dist_cm=401, valid trig -> echo width 38000 ticks; dist_cm=0 -> echo width 1 tick.
- dist_cm=200 at trig fall, changed to 10 during DELAY -> echo width still 11600 ticks.
- Second 12 us trig during ECHO and another during HOLDOFF (HOLDOFF_US=100 override) -> both ignored, single echo; a trig after holdoff produces a new echo.
- Reset pulsed low mid-ECHO -> echo=0 immediately, busy=0, no meas_done; next valid trig measures normally. With SR04_ECHO_JITTER_EN, 16 triggers at dist_cm=10 -> widths are all within 580..587 and not all equal.
